// File: rtl/digit_scan4.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered display register.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (3..1).
module digit_scan4 #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        blank,
    output logic        frame_done,
    output logic [1:0]  o_dbg_state
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sel;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_blank;
    logic               r_frame_done;
    logic [19:0]        r_pending;
    logic [19:0]        r_display;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [1:0]         w_sel_nx;
    logic               w_wrap;
    logic               w_take;
    logic [19:0]        w_pending_nx;
    logic [19:0]        w_display_nx;
    logic [3:0]         w_nib;
    logic [3:0]         w_dp_vec;
    logic               w_dp_bit;
    logic               w_lz;
    logic [6:0]         w_seg_nx;
    logic               w_dp_nx;
    logic               w_blank_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan sequencing: en low wins from any state; a wrap is sel 3->0 inside a running scan.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_wrap     = 1'b0;
        w_take     = 1'b0;
        if (!en) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_sel_nx   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_SHOW;
                    w_cnt_nx   = '0;
                    w_sel_nx   = 2'd0;
                    w_take     = 1'b1;
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_cnt_nx = '0;
                        if (BLANK_CYCLES == 0) begin
                            w_sel_nx = r_sel + 2'd1;
                            w_wrap   = (r_sel == 2'd3);
                            w_take   = (r_sel == 2'd3);
                        end else begin
                            w_state_nx = ST_GAP;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nx = ST_SHOW;
                        w_cnt_nx   = '0;
                        w_sel_nx   = r_sel + 2'd1;
                        w_wrap     = (r_sel == 2'd3);
                        w_take     = (r_sel == 2'd3);
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_sel_nx   = 2'd0;
                end
            endcase
        end
    end

    // load is a fire-and-forget strobe (no ready): it always lands in pending, and
    // a load on a display-update edge bypasses straight into the new frame.
    always_comb begin
        w_pending_nx = load ? {dp_in, data} : r_pending;
        w_display_nx = w_take ? w_pending_nx : r_display;
        w_dp_vec     = w_display_nx[19:16];
        w_dp_bit     = w_dp_vec[w_sel_nx];
        case (w_sel_nx)
            2'd0:    w_nib = w_display_nx[3:0];
            2'd1:    w_nib = w_display_nx[7:4];
            2'd2:    w_nib = w_display_nx[11:8];
            default: w_nib = w_display_nx[15:12];
        endcase
    end

    always_comb begin
        w_lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (w_sel_nx)
            2'd3:    w_lz = (w_display_nx[15:12] == 4'h0);
            2'd2:    w_lz = (w_display_nx[15:8] == 8'h00);
            2'd1:    w_lz = (w_display_nx[15:4] == 12'h000);
            default: w_lz = 1'b0;
        endcase
`else
        w_lz = 1'b0;
`endif
    end

    // Outputs are computed from next-state values so seg/dp move together with sel.
    always_comb begin
        w_seg_nx   = 7'h00;
        w_dp_nx    = 1'b0;
        w_blank_nx = 1'b1;
        if (w_state_nx == ST_SHOW) begin
            w_blank_nx = 1'b0;
            w_seg_nx   = w_lz ? 7'h00 : hex7(w_nib);
            w_dp_nx    = w_dp_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_seg        <= 7'h00;
            r_dp         <= 1'b0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
            r_pending    <= '0;
            r_display    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_sel        <= w_sel_nx;
            r_seg        <= w_seg_nx;
            r_dp         <= w_dp_nx;
            r_blank      <= w_blank_nx;
            r_frame_done <= w_wrap;
            r_pending    <= w_pending_nx;
            r_display    <= w_display_nx;
        end
    end

    assign sel         = r_sel;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign blank       = r_blank;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_digit_scan4.sv
// Scoreboard bench for digit_scan4: a PRESCALE=4/BLANK=2 instance and a PRESCALE=2/BLANK=0 instance.
module tb_digit_scan4;

    localparam int W = 12;  // {sel[1:0], seg[6:0], dp, blank, frame_done}

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h00;
`else
    localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

    logic        clk;
    logic        reset;

    logic        en_a, load_a;
    logic [15:0] data_a;
    logic [3:0]  dp_in_a;
    logic [1:0]  sel_a;
    logic [6:0]  seg_a;
    logic        dp_a, blank_a, fd_a;
    logic [1:0]  st_a;

    logic        en_b, load_b;
    logic [15:0] data_b;
    logic [3:0]  dp_in_b;
    logic [1:0]  sel_b;
    logic [6:0]  seg_b;
    logic        dp_b, blank_b, fd_b;
    logic [1:0]  st_b;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [W-1:0] e_a, act_a, e_b, act_b;

    int checks;
    int errors;
    logic flush;

    digit_scan4 #(.PRESCALE(4), .BLANK_CYCLES(2)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .en          (en_a),
        .load        (load_a),
        .data        (data_a),
        .dp_in       (dp_in_a),
        .sel         (sel_a),
        .seg         (seg_a),
        .dp          (dp_a),
        .blank       (blank_a),
        .frame_done  (fd_a),
        .o_dbg_state (st_a)
    );

    digit_scan4 #(.PRESCALE(2), .BLANK_CYCLES(0)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .en          (en_b),
        .load        (load_b),
        .data        (data_b),
        .dp_in       (dp_in_b),
        .sel         (sel_b),
        .seg         (seg_b),
        .dp          (dp_b),
        .blank       (blank_b),
        .frame_done  (fd_b),
        .o_dbg_state (st_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: wait for the edge, then queue what the outputs must show after it
    task automatic step_a(input logic [1:0] s, input logic [6:0] g, input logic d,
                          input logic b, input logic f);
        @(posedge clk);
        #1;
        exp_q.push_back({s, g, d, b, f});
    endtask

    task automatic digit_a(input logic [1:0] s, input logic [6:0] g, input logic d,
                           input logic f);
        for (int i = 0; i < 4; i++) begin
            step_a(s, g, d, 1'b0, (i == 0) ? f : 1'b0);
            load_a = 1'b0;
        end
        for (int i = 0; i < 2; i++) step_a(s, 7'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic step_b(input logic [1:0] s, input logic [6:0] g, input logic d,
                          input logic f);
        @(posedge clk);
        #1;
        exp_b_q.push_back({s, g, d, 1'b0, f});
        load_b = 1'b0;
    endtask

    task automatic frame_b(input logic f);
        step_b(2'd0, 7'h06, 1'b0, f);
        step_b(2'd0, 7'h06, 1'b0, 1'b0);
        step_b(2'd1, 7'h5B, 1'b0, 1'b0);
        step_b(2'd1, 7'h5B, 1'b0, 1'b0);
        step_b(2'd2, 7'h4F, 1'b0, 1'b0);
        step_b(2'd2, 7'h4F, 1'b0, 1'b0);
        step_b(2'd3, 7'h66, 1'b1, 1'b0);
        step_b(2'd3, 7'h66, 1'b1, 1'b0);
    endtask

    // scoreboard monitor: one pop per presented cycle, per instance
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_a   = exp_q.pop_front();
            act_a = {sel_a, seg_a, dp_a, blank_a, fd_a};
            checks++;
            if (act_a !== e_a) begin
                errors++;
                $display("FAIL a_out t=%0t: got sel=%0d seg=%h dp=%b blank=%b fd=%b, want sel=%0d seg=%h dp=%b blank=%b fd=%b",
                         $time, act_a[11:10], act_a[9:3], act_a[2], act_a[1], act_a[0],
                         e_a[11:10], e_a[9:3], e_a[2], e_a[1], e_a[0]);
            end
        end
        if (exp_b_q.size() != 0) begin
            e_b   = exp_b_q.pop_front();
            act_b = {sel_b, seg_b, dp_b, blank_b, fd_b};
            checks++;
            if (act_b !== e_b) begin
                errors++;
                $display("FAIL b_out t=%0t: got sel=%0d seg=%h dp=%b blank=%b fd=%b, want sel=%0d seg=%h dp=%b blank=%b fd=%b",
                         $time, act_b[11:10], act_b[9:3], act_b[2], act_b[1], act_b[0],
                         e_b[11:10], e_b[9:3], e_b[2], e_b[1], e_b[0]);
            end
        end
        if (flush && (exp_q.size() != 0 || exp_b_q.size() != 0)) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", exp_q.size(), exp_b_q.size());
            exp_q.delete();
            exp_b_q.delete();
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        flush   = 1'b0;
        reset   = 1'b1;
        en_a    = 1'b1;
        load_a  = 1'b0;
        data_a  = 16'h0000;
        dp_in_a = 4'h0;
        en_b    = 1'b0;
        load_b  = 1'b0;
        data_b  = 16'h0000;
        dp_in_b = 4'h0;

        // reset held with en=1: both instances stay dark at digit 0
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back({2'd0, 7'h00, 1'b0, 1'b1, 1'b0});
            exp_b_q.push_back({2'd0, 7'h00, 1'b0, 1'b1, 1'b0});
        end

        // release with a load on the IDLE->SHOW edge
        reset   = 1'b0;
        load_a  = 1'b1;
        data_a  = 16'h1A08;
        dp_in_a = 4'b0100;

        // frame 1: no frame_done on the start from IDLE
        digit_a(2'd0, 7'h7F, 1'b0, 1'b0);
        digit_a(2'd1, 7'h3F, 1'b0, 1'b0);
        digit_a(2'd2, 7'h77, 1'b1, 1'b0);
        digit_a(2'd3, 7'h06, 1'b0, 1'b0);

        // frame 2: FFFF loaded entering digit 1 must not tear this frame
        digit_a(2'd0, 7'h7F, 1'b0, 1'b1);
        load_a  = 1'b1;
        data_a  = 16'hFFFF;
        dp_in_a = 4'b0000;
        digit_a(2'd1, 7'h3F, 1'b0, 1'b0);
        digit_a(2'd2, 7'h77, 1'b1, 1'b0);
        digit_a(2'd3, 7'h06, 1'b0, 1'b0);

        // frame 3: new value everywhere
        digit_a(2'd0, 7'h71, 1'b0, 1'b1);
        digit_a(2'd1, 7'h71, 1'b0, 1'b0);
        digit_a(2'd2, 7'h71, 1'b0, 1'b0);
        digit_a(2'd3, 7'h71, 1'b0, 1'b0);

        // frame 4: load on the wrap edge shows in the same frame
        load_a  = 1'b1;
        data_a  = 16'h0050;
        dp_in_a = 4'b0001;
        digit_a(2'd0, 7'h3F, 1'b1, 1'b1);
        digit_a(2'd1, 7'h6D, 1'b0, 1'b0);
        digit_a(2'd2, LZ_SEG, 1'b0, 1'b0);
        digit_a(2'd3, LZ_SEG, 1'b0, 1'b0);

        // frame 5: drop en two cycles into digit 2
        digit_a(2'd0, 7'h3F, 1'b1, 1'b1);
        digit_a(2'd1, 7'h6D, 1'b0, 1'b0);
        step_a(2'd2, LZ_SEG, 1'b0, 1'b0, 1'b0);
        step_a(2'd2, LZ_SEG, 1'b0, 1'b0, 1'b0);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) step_a(2'd0, 7'h00, 1'b0, 1'b1, 1'b0);

        // re-enable: digit 0 with the full count, pending retained, no frame_done
        en_a = 1'b1;
        digit_a(2'd0, 7'h3F, 1'b1, 1'b0);
        digit_a(2'd1, 7'h6D, 1'b0, 1'b0);
        en_a = 1'b0;
        step_a(2'd0, 7'h00, 1'b0, 1'b1, 1'b0);

        // instance B: no gap, 2 cycles per digit, frame_done every 8 cycles
        en_b    = 1'b1;
        load_b  = 1'b1;
        data_b  = 16'h4321;
        dp_in_b = 4'b1000;
        frame_b(1'b0);
        frame_b(1'b1);
        step_b(2'd0, 7'h06, 1'b0, 1'b1);
        en_b = 1'b0;

        @(posedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_scan4.md
Name: digit_scan4

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode/cathode 7-segment display.
- Sits directly upstream of the 2-to-4 digit decoder. Its `sel[1:0]` output drives the decoder input, and the decoder's one-hot output becomes the digit enables.
- Holds a 16-bit hex value (4 nibbles), steps through the digits at a prescaled rate with an anti-ghosting blank gap, and outputs the segment pattern for the current digit.
- Double-buffers the data so a frame never shows a mix of old and new values.

Parameters:
- PRESCALE, 50000, clock cycles each digit is lit (SHOW duration); legal range ≥2.
- BLANK_CYCLES, 16, dark cycles between digits (GAP duration); 0 means no GAP state.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- en  in  1  scan enable; low forces IDLE (all dark).
- load  in  1  one-cycle strobe; captures `data`/`dp_in` into the pending register.
- data  in  16  hex digits; `data[4k+3:4k]` is shown on digit k.
- dp_in  in  4  decimal point per digit; bit k belongs to digit k.
- sel  out  2  current digit index, to the 2-to-4 decoder.
- seg  out  7  segment pattern, active-high, `seg[0]`=a … `seg[6]`=g.
- dp  out  1  decimal point for the current digit, active-high.
- blank  out  1  high means decoder outputs must be gated off (no digit lit).
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- All outputs and state are registered; `seg`/`dp` change in the same cycle as `sel`.
- Reset values (asynchronous):
  - sel=0, seg=0, dp=0, blank=1, frame_done=0
  - state=IDLE, counter=0, pending=0, display=0
- Pending register: on `load`=1, `pending` ← {dp_in, data}, independent of state.
- Display register: `display` ← `pending` on IDLE→SHOW and at every frame boundary (the edge where sel wraps 3→0).
  - If `load` coincides with that edge, `display` takes the new `data`/`dp_in` (load wins, bypass).
- States:
  - IDLE: blank=1, sel=0, seg=0, dp=0, counter=0. Goes to SHOW on the next edge when en=1.
  - SHOW: blank=0; seg = hex7(display nibble[sel]); dp = display dp[sel]. The counter runs 0..PRESCALE-1.
    - At PRESCALE-1, go to GAP, or, if BLANK_CYCLES=0, advance sel and stay in SHOW.
  - GAP: blank=1, seg=0, dp=0, sel held. The counter runs 0..BLANK_CYCLES-1, then sel advances and the state returns to SHOW.
- sel increments modulo 4, wrapping 3→0.
  - frame_done=1 for exactly the one cycle following the wrap edge, aligned with the first cycle of digit 0's SHOW.
- Frame length = 4·(PRESCALE+BLANK_CYCLES) cycles. Counter width = $clog2(max(PRESCALE, BLANK_CYCLES, 2)).
- hex7 encoding (a..g active-high, shown as seg[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- en dropping in any state: the next edge enters IDLE; outputs take IDLE values and frame_done is not pulsed. The pending register is retained.
- Reset asserted mid-frame: immediate return to reset values, with no glitch ordering requirement beyond `blank`=1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: digit k (k=3,2,1) shows seg=0 and dp=dp_in bit while the display nibbles k..3 are all zero. Digit 0 is always shown. Timing, sel, and blank are unchanged.
- When undefined: every digit shows its hex value, including leading zeros.

Test Plan:
- Reset defaults: reset=1 with en=1 → sel=0, blank=1, seg=0, frame_done=0. After release and one edge: SHOW, blank=0.
- Basic scan, PRESCALE=4, BLANK_CYCLES=2, load data=16'h1A08, dp_in=4'b0100, en=1:
  - Sequence of sel=0 seg=7F for 4 cycles, then blank=1 for 2 cycles.
  - Then sel=1 seg=3F; then sel=2 seg=77 dp=1; then sel=3 seg=06.
  - frame_done pulses once every 24 cycles.
- Tear-free update: load data=16'hFFFF mid-frame while sel=1 → digits 1–3 keep the old values. The next frame shows seg=71 on all digits. Load on the wrap edge takes effect in that same frame.
- BLANK_CYCLES=0, PRESCALE=2 → sel advances every 2 cycles, blank stays 0 while en=1, frame_done every 8 cycles.
- en deasserted at sel=2 mid-SHOW → next cycle blank=1, sel=0, seg=0. Re-enable restarts at digit 0 with the full PRESCALE count.
- LEADING_ZERO_BLANK_EN defined, data=16'h0050 → digits 3 and 2 seg=0, digit 1 seg=6D, digit 0 seg=3F. Macro undefined → digits 3 and 2 seg=3F.
